spi_cmd_decoder: RTL and testbench

Parametrised byte-stream command decoder for the hashing ASIC SPI slave path; successor to the fixed 15-bit address decoder. Consumes framed bytes from the SPI deserializer, decodes a command byte carrying R/W and a chip ID, assembles a multi-byte address, and issues register-file read/write strobes with auto-incrementing bursts. Sits between the SPI deserializer and the register bank; also supplies the address snapshot consumed by the passthrough ID-assignment logic.

---
 rtl/spi_cmd_decoder_pkg.sv | 23 ++
 rtl/spi_cmd_decoder_addr_shift.sv | 38 +++
 rtl/spi_cmd_decoder.sv | 175 +++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_decoder_pkg.sv
// spi_cmd_decoder shared definitions.
// FSM state encoding, command-byte layout and width helpers.
package spi_cmd_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DISCARD
    } state_t;

    localparam int RW_BIT = 7;

    function automatic int addr_bytes(input int w);
        return (w + 7) / 8;
    endfunction

    function automatic int bcast_id(input int id_w);
        return (1 << id_w) - 1;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_addr_shift.sv
// spi_cmd_decoder address register.
// MSB-first byte assembly plus wrapping post-increment.
module spi_cmd_decoder_addr_shift #(
    parameter int ADDR_W = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_shift,
    input  logic [7:0]        i_byte,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_shifted;

    generate
        if (ADDR_W > 8) begin : g_wide
            assign w_shifted = {r_addr[ADDR_W-9:0], i_byte};
        end else begin : g_narrow
            assign w_shifted = i_byte[ADDR_W-1:0];
        end
    endgenerate

    // Shift in address bytes, or step to the next register (wraps).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr <= '0;
        end else if (i_shift) begin
            r_addr <= w_shifted;
        end else if (i_inc) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: SPI byte-stream command/address/data decoder.
// Define SPI_CMD_AUTOINC_EN to post-increment the address in bursts.
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int              ADDR_W    = 15,
    parameter int              ID_W      = 7,
    parameter int              MAX_BURST = 64,
    parameter logic [ID_W-1:0] BCAST_ID  = ID_W'(bcast_id(ID_W))
) (
    input  logic              iCLK,
    input  logic              RST_N,
    input  logic [ID_W-1:0]   my_id,
    input  logic              write_enable_mask,
    input  logic              start_of_transfer,
    input  logic              end_of_transfer,
    input  logic [7:0]        data_in_value,
    input  logic              data_in_ready,
    input  logic              data_out_request,
    output logic [ADDR_W-1:0] ram_address_out,
    output logic [7:0]        ram_data_out,
    output logic              address_strobe,
    output logic              ram_read_strobe,
    output logic              ram_write_strobe,
    output logic              id_match,
    output logic              xfer_active,
    output logic              burst_overflow
);

    localparam int AB = addr_bytes(ADDR_W);
    localparam int CW = $clog2(MAX_BURST + 1);

`ifdef SPI_CMD_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    state_t      r_state;
    logic        r_rw;
    logic [2:0]  r_abyte;
    logic [CW-1:0] r_cnt;
    logic        r_inc_pend;
    logic        r_pref;
    logic        r_id_match;
    logic        r_xfer;
    logic        r_ovf;
    logic [7:0]  r_data;
    logic        r_astb;
    logic        r_rstb;
    logic        r_wstb;

    logic [ID_W-1:0] w_id;
    logic        w_rw;
    logic        w_match;
    logic        w_bcast_rd;
    logic        w_cmd;
    logic        w_shift;
    logic        w_full;
    logic        w_rd_req;
    logic        w_inc;

    assign w_id       = data_in_value[ID_W-1:0];
    assign w_rw       = data_in_value[RW_BIT];
    assign w_match    = (w_id == my_id) || (w_id == BCAST_ID);
    assign w_bcast_rd = (w_id == BCAST_ID) && !w_rw;
    assign w_cmd      = data_in_ready
                      && (start_of_transfer || r_state == ST_CMD);
    assign w_shift    = data_in_ready && !start_of_transfer
                      && r_state == ST_ADDR;
    assign w_full     = r_cnt == CW'(MAX_BURST);
    assign w_rd_req   = data_out_request && !start_of_transfer
                      && r_state == ST_DATA && !r_rw && !w_full;
    assign w_inc      = AUTOINC && (r_inc_pend || w_rd_req);

    spi_cmd_decoder_addr_shift #(
        .ADDR_W (ADDR_W)
    ) u_addr (
        .i_clk   (iCLK),
        .i_rst_n (RST_N),
        .i_shift (w_shift),
        .i_byte  (data_in_value),
        .i_inc   (w_inc),
        .o_addr  (ram_address_out)
    );

    // Frame sequencer: command, address, data phases and strobes.
    always_ff @(posedge iCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_rw       <= 1'b0;
            r_abyte    <= '0;
            r_cnt      <= '0;
            r_inc_pend <= 1'b0;
            r_pref     <= 1'b0;
            r_id_match <= 1'b0;
            r_xfer     <= 1'b0;
            r_ovf      <= 1'b0;
            r_data     <= '0;
            r_astb     <= 1'b0;
            r_rstb     <= 1'b0;
            r_wstb     <= 1'b0;
        end else begin
            r_astb     <= 1'b0;
            r_wstb     <= 1'b0;
            r_rstb     <= r_pref;
            r_pref     <= 1'b0;
            r_inc_pend <= 1'b0;
            if (start_of_transfer) begin
                r_state    <= ST_CMD;
                r_xfer     <= 1'b1;
                r_cnt      <= '0;
                r_abyte    <= '0;
                r_ovf      <= 1'b0;
                r_id_match <= 1'b0;
            end
            if (w_cmd) begin
                r_rw       <= w_rw;
                r_id_match <= w_match;
                r_state    <= (w_match && !w_bcast_rd) ? ST_ADDR
                                                       : ST_DISCARD;
            end else if (!start_of_transfer) begin
                case (r_state)
                    ST_ADDR: begin
                        if (data_in_ready) begin
                            r_abyte <= r_abyte + 3'd1;
                            if (r_abyte == 3'(AB - 1)) begin
                                r_astb  <= 1'b1;
                                r_pref  <= !r_rw;
                                r_state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (r_rw && data_in_ready) begin
                            if (w_full) begin
                                r_state <= ST_DISCARD;
                                r_ovf   <= 1'b1;
                            end else begin
                                r_cnt      <= r_cnt + CW'(1);
                                r_inc_pend <= 1'b1;
                                if (write_enable_mask) begin
                                    r_wstb <= 1'b1;
                                    r_data <= data_in_value;
                                end
                            end
                        end else if (!r_rw && data_out_request) begin
                            if (w_full) begin
                                r_state <= ST_DISCARD;
                                r_ovf   <= 1'b1;
                            end else begin
                                r_cnt  <= r_cnt + CW'(1);
                                r_rstb <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (end_of_transfer && !start_of_transfer) begin
                r_state <= ST_IDLE;
                r_xfer  <= 1'b0;
            end
        end
    end

    assign ram_data_out     = r_data;
    assign address_strobe   = r_astb;
    assign ram_read_strobe  = r_rstb;
    assign ram_write_strobe = r_wstb;
    assign id_match         = r_id_match;
    assign xfer_active      = r_xfer;
    assign burst_overflow   = r_ovf;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Testbench for spi_cmd_decoder.
// Frame-level scoreboard plus directed literal checks.
module tb_spi_cmd_decoder;

    localparam int MAXB = 4;
    localparam logic [6:0] MY_ID = 7'd5;
`ifdef SPI_CMD_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic        iCLK;
    logic        RST_N;
    logic [6:0]  my_id;
    logic        write_enable_mask;
    logic        start_of_transfer;
    logic        end_of_transfer;
    logic [7:0]  data_in_value;
    logic        data_in_ready;
    logic        data_out_request;
    logic [14:0] ram_address_out;
    logic [7:0]  ram_data_out;
    logic        address_strobe;
    logic        ram_read_strobe;
    logic        ram_write_strobe;
    logic        id_match;
    logic        xfer_active;
    logic        burst_overflow;

    spi_cmd_decoder #(
        .ADDR_W    (15),
        .ID_W      (7),
        .MAX_BURST (MAXB)
    ) dut (
        .iCLK              (iCLK),
        .RST_N             (RST_N),
        .my_id             (my_id),
        .write_enable_mask (write_enable_mask),
        .start_of_transfer (start_of_transfer),
        .end_of_transfer   (end_of_transfer),
        .data_in_value     (data_in_value),
        .data_in_ready     (data_in_ready),
        .data_out_request  (data_out_request),
        .ram_address_out   (ram_address_out),
        .ram_data_out      (ram_data_out),
        .address_strobe    (address_strobe),
        .ram_read_strobe   (ram_read_strobe),
        .ram_write_strobe  (ram_write_strobe),
        .id_match          (id_match),
        .xfer_active       (xfer_active),
        .burst_overflow    (burst_overflow)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit run = 0;

    bit          ew[int];
    bit          er[int];
    bit          ea[int];
    logic [14:0] eaddr[int];
    logic [7:0]  edata[int];

    logic [14:0] wla[$];
    logic [7:0]  wld[$];
    logic [14:0] rla[$];
    logic [14:0] ala[$];

    logic [7:0]  fdata[8];

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h",
                     nm, cyc, got, exp);
        end
    endtask

    // Per-cycle comparison of strobes against the scoreboard.
    always @(negedge iCLK) begin
        if (RST_N && run) begin
            bit xw, xr, xa;
            xw = ew.exists(cyc);
            xr = er.exists(cyc);
            xa = ea.exists(cyc);
            chk("wstb", 32'(ram_write_strobe), 32'(xw));
            chk("rstb", 32'(ram_read_strobe), 32'(xr));
            chk("astb", 32'(address_strobe), 32'(xa));
            if (xw || xr || xa)
                chk("addr", 32'(ram_address_out), 32'(eaddr[cyc]));
            if (xw)
                chk("wdata", 32'(ram_data_out), 32'(edata[cyc]));
            if (ram_write_strobe) begin
                wla.push_back(ram_address_out);
                wld.push_back(ram_data_out);
            end
            if (ram_read_strobe) rla.push_back(ram_address_out);
            if (address_strobe) ala.push_back(ram_address_out);
        end
    end

    task automatic clear_logs();
        wla.delete();
        wld.delete();
        rla.delete();
        ala.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic gap(input int mg);
        if (mg > 0) idle(int'($urandom_range(mg, 0)));
    endtask

    task automatic cyc_in(input bit sof, input bit eof, input bit dr,
                          input logic [7:0] v, input bit req,
                          output int d);
        start_of_transfer = sof;
        end_of_transfer   = eof;
        data_in_ready     = dr;
        data_in_value     = v;
        data_out_request  = req;
        d = cyc;
        @(posedge iCLK);
        #1;
        start_of_transfer = 1'b0;
        end_of_transfer   = 1'b0;
        data_in_ready     = 1'b0;
        data_in_value     = 8'h00;
        data_out_request  = 1'b0;
    endtask

    // One complete frame; expected strobes derived from the frame rules.
    task automatic frame(input logic [7:0] cmd, input logic [14:0] a,
                         input int n, input bit msk, input bit joint,
                         input bit eof_last, input int mg);
        int d, dl;
        logic [6:0] id;
        logic [7:0] b0;
        bit rw, m, act, e;
        id  = cmd[6:0];
        rw  = cmd[7];
        m   = (id == MY_ID) || (id == 7'h7F);
        act = m && (rw || id != 7'h7F);
        write_enable_mask = msk;
        if (joint) begin
            cyc_in(1, 0, 1, cmd, 0, d);
        end else begin
            cyc_in(1, 0, 0, 8'h00, 0, d);
            gap(mg);
            cyc_in(0, 0, 1, cmd, 0, d);
        end
        chk("xfer_on", 32'(xfer_active), 32'd1);
        b0 = {1'($urandom_range(1, 0)), a[14:8]};
        gap(mg);
        cyc_in(0, 0, 1, b0, 0, d);
        gap(mg);
        cyc_in(0, 0, 1, a[7:0], 0, dl);
        if (act) begin
            ea[dl+1] = 1'b1;
            eaddr[dl+1] = a;
            if (!rw) begin
                er[dl+2] = 1'b1;
                eaddr[dl+2] = a;
            end
        end
        if (!rw) idle(1);
        for (int k = 0; k < n; k++) begin
            e = eof_last && (k == n - 1);
            gap(mg);
            if (rw) begin
                cyc_in(0, e, 1, fdata[k], 0, d);
                if (act && k < MAXB && msk) begin
                    ew[d+1] = 1'b1;
                    eaddr[d+1] = a + 15'(AI ? k : 0);
                    edata[d+1] = fdata[k];
                end
            end else begin
                cyc_in(0, e, 0, 8'($urandom), 1, d);
                if (act && k < MAXB) begin
                    er[d+1] = 1'b1;
                    eaddr[d+1] = a + 15'(AI ? k + 1 : 0);
                end
            end
        end
        if (!(eof_last && n > 0)) begin
            gap(mg);
            cyc_in(0, 1, 0, 8'h00, 0, d);
        end
        idle(2);
        chk("xfer_off", 32'(xfer_active), 32'd0);
        chk("id_match", 32'(id_match), 32'(m));
        chk("overflow", 32'(burst_overflow), 32'(act && n > MAXB));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int d, dl;
        RST_N             = 1'b0;
        my_id             = MY_ID;
        write_enable_mask = 1'b1;
        start_of_transfer = 1'b0;
        end_of_transfer   = 1'b0;
        data_in_value     = 8'h00;
        data_in_ready     = 1'b0;
        data_out_request  = 1'b0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        RST_N = 1'b1;
        @(posedge iCLK);
        #1;
        run = 1'b1;
        chk("rst_addr", 32'(ram_address_out), 32'd0);
        chk("rst_data", 32'(ram_data_out), 32'd0);
        chk("rst_strobes", 32'({address_strobe, ram_read_strobe,
                                ram_write_strobe}), 32'd0);
        chk("rst_flags", 32'({id_match, xfer_active, burst_overflow}),
            32'd0);

        // Basic write 0x85,0x01,0x20,0xAA,0xBB
        clear_logs();
        fdata[0] = 8'hAA;
        fdata[1] = 8'hBB;
        frame(8'h85, 15'h0120, 2, 1, 1, 0, 0);
        chk("t1_astb_addr", 32'(ala[0]), 32'h0120);
        chk("t1_nw", wla.size(), 2);
        chk("t1_w0_addr", 32'(wla[0]), 32'h0120);
        chk("t1_w0_data", 32'(wld[0]), 32'hAA);
        chk("t1_w1_addr", 32'(wla[1]), AI ? 32'h0121 : 32'h0120);
        chk("t1_w1_data", 32'(wld[1]), 32'hBB);

        // Read at 0x7FFF with two requests (wrap)
        clear_logs();
        frame(8'h05, 15'h7FFF, 2, 1, 1, 0, 0);
        chk("wrap_nr", rla.size(), 3);
        chk("wrap_r0", 32'(rla[0]), 32'h7FFF);
        chk("wrap_r1", 32'(rla[1]), AI ? 32'h0000 : 32'h7FFF);
        chk("wrap_r2", 32'(rla[2]), AI ? 32'h0001 : 32'h7FFF);

        // Foreign ID and broadcast
        clear_logs();
        frame(8'h83, 15'h0010, 2, 1, 1, 0, 0);
        chk("id3_nw", wla.size(), 0);
        chk("id3_na", ala.size(), 0);
        chk("id3_match", 32'(id_match), 32'd0);
        clear_logs();
        frame(8'hFF, 15'h0200, 2, 1, 1, 0, 0);
        chk("bc_wr_nw", wla.size(), 2);
        clear_logs();
        frame(8'h7F, 15'h0200, 2, 1, 1, 0, 0);
        chk("bc_rd_nr", rla.size(), 0);
        chk("bc_rd_na", ala.size(), 0);

        // Burst overflow, cleared by next start
        clear_logs();
        for (int i = 0; i < 8; i++) fdata[i] = 8'(8'h10 + i);
        frame(8'h85, 15'h0300, 6, 1, 1, 0, 0);
        chk("ovf_nw", wla.size(), 4);
        chk("ovf_last", 32'(wla[3]), AI ? 32'h0303 : 32'h0300);
        chk("ovf_set", 32'(burst_overflow), 32'd1);
        cyc_in(1, 0, 0, 8'h00, 0, d);
        chk("ovf_clr", 32'(burst_overflow), 32'd0);

        // Abort mid-ADDR, then a fresh frame
        cyc_in(0, 0, 1, 8'h85, 0, d);
        cyc_in(0, 0, 1, 8'h3A, 0, d);
        clear_logs();
        fdata[0] = 8'h5A;
        frame(8'h85, 15'h0055, 1, 1, 1, 0, 0);
        chk("abort_astb", 32'(ala[0]), 32'h0055);
        chk("abort_w_addr", 32'(wla[0]), 32'h0055);
        chk("abort_w_data", 32'(wld[0]), 32'h5A);

        // Frame ends inside ADDR
        clear_logs();
        cyc_in(1, 0, 1, 8'h85, 0, d);
        cyc_in(0, 0, 1, 8'h12, 0, d);
        cyc_in(0, 1, 0, 8'h00, 0, d);
        idle(2);
        chk("part_addr", 32'(ram_address_out[7:0]), 32'h12);
        chk("part_na", ala.size(), 0);
        chk("part_xfer", 32'(xfer_active), 32'd0);

        // Fixed or incrementing address over three writes at 0x0040
        clear_logs();
        fdata[0] = 8'h11;
        fdata[1] = 8'h22;
        fdata[2] = 8'h33;
        frame(8'h85, 15'h0040, 3, 1, 0, 1, 1);
        chk("fix_nw", wla.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("fix_addr", 32'(wla[i]), 32'h0040 + (AI ? i : 0));

        // Asynchronous reset in the middle of DATA
        write_enable_mask = 1'b1;
        cyc_in(1, 0, 1, 8'h85, 0, d);
        cyc_in(0, 0, 1, 8'h01, 0, d);
        cyc_in(0, 0, 1, 8'h20, 0, dl);
        ea[dl+1] = 1'b1;
        eaddr[dl+1] = 15'h0120;
        cyc_in(0, 0, 1, 8'hAA, 0, d);
        ew[d+1] = 1'b1;
        eaddr[d+1] = 15'h0120;
        edata[d+1] = 8'hAA;
        chk("prerst_wstb", 32'(ram_write_strobe), 32'd1);
        @(negedge iCLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_addr", 32'(ram_address_out), 32'd0);
        chk("arst_data", 32'(ram_data_out), 32'd0);
        chk("arst_strobes", 32'({address_strobe, ram_read_strobe,
                                 ram_write_strobe}), 32'd0);
        chk("arst_flags", 32'({id_match, xfer_active, burst_overflow}),
            32'd0);
        @(posedge iCLK);
        #3;
        RST_N = 1'b1;
        @(posedge iCLK);
        #1;

        // Randomized frames against the scoreboard
        repeat (150) begin
            int sel, n;
            logic [6:0] id;
            logic [7:0] c;
            logic [14:0] a;
            sel = int'($urandom_range(3, 0));
            id = (sel < 2) ? MY_ID : (sel == 2) ? 7'h7F : 7'($urandom);
            c = {1'($urandom_range(1, 0)), id};
            a = $urandom_range(1, 0) != 0
              ? 15'h7FFF - 15'($urandom_range(3, 0))
              : 15'($urandom);
            n = int'($urandom_range(6, 0));
            for (int i = 0; i < 8; i++) fdata[i] = 8'($urandom);
            frame(c, a, n, $urandom_range(7, 0) != 0,
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  int'($urandom_range(2, 0)));
        end

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
